// File: rtl/pingpong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_pkg
//  Purpose  : Shared types and constants for the ping-pong feature buffer.
//             Holds the bank ownership state encoding, the DMA mem_enable
//             command encodings, default widths and the fill-length helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pingpong_pkg;

   localparam int DATA_W = 256;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_t;

   localparam logic [1:0] MEM_IDLE = 2'b00;
   localparam logic [1:0] MEM_RD   = 2'b01;
   localparam logic [1:0] MEM_WR   = 2'b10;

   // A fill length of 0, or anything larger than a bank, means "whole bank".
   function automatic logic [6:0] eff_fill_len(input logic [6:0] len);
      if ((len == 7'd0) || (len > 7'd64)) begin
         return 7'd64;
      end
      return len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pp_bank.sv
`default_nettype none
// ============================================================================
//  Module   : pp_bank
//  Purpose  : One bank of the ping-pong buffer: RAM, ownership FSM
//             (EMPTY/FILLING/FULL/DRAINING), fill counter and the shared
//             read-data register. Optional per-word even parity when
//             PINGPONG_PARITY_EN is defined.
//  Ports    : clk_h, rst_n        clock / synchronous active-low reset
//             cfg_fill_len        fill length, latched on first write
//             wr_req/dma_rd_req   DMA write / read attempt aimed at this bank
//             dma_addr, wr_data   DMA address and write data
//             pe_start/pe_done    claim / release (already steered by top)
//             pe_rd_req/addr      PE read attempt aimed at this bank
//             wr_ready            bank accepts DMA writes
//             is_full/is_draining ownership status
//             rd_data             registered read data (DMA or PE)
//             dma_rd_valid        rd_data holds a DMA read result
//             pe_rd_valid         rd_data holds a PE read result
//             parity_err          parity mismatch, aligned with pe_rd_valid
//  Revision : 1.0 - initial release
// ============================================================================
module pp_bank #(
   parameter int DATA_W = pingpong_pkg::DATA_W,
   parameter int ADDR_W = pingpong_pkg::ADDR_W
) (
   input  logic              clk_h,
   input  logic              rst_n,
   input  logic [6:0]        cfg_fill_len,
   input  logic              wr_req,
   input  logic              dma_rd_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pe_start,
   input  logic              pe_rd_req,
   input  logic [ADDR_W-1:0] pe_rd_addr,
   input  logic              pe_done,
   output logic              wr_ready,
   output logic              is_full,
   output logic              is_draining,
   output logic [DATA_W-1:0] rd_data,
   output logic              dma_rd_valid,
   output logic              pe_rd_valid,
   output logic              parity_err
);
   import pingpong_pkg::*;

   localparam int BANK_DEPTH = 2 ** ADDR_W;

   bank_state_t       r_state;
   bank_state_t       w_state_nxt;
   logic [6:0]        r_count;
   logic [6:0]        w_count_nxt;
   logic [6:0]        r_fill_len;
   logic [6:0]        w_fill_len_nxt;
   logic [6:0]        w_len_eff;
   logic [6:0]        w_count_inc;
   logic [DATA_W-1:0] r_ram [BANK_DEPTH];
   logic              w_wr_ok;
   logic              w_dma_rd_ok;
   logic              w_pe_rd_ok;
   logic [ADDR_W-1:0] w_rd_addr;

   assign wr_ready    = (r_state == EMPTY) || (r_state == FILLING);
   assign is_full     = (r_state == FULL);
   assign is_draining = (r_state == DRAINING);

   assign w_wr_ok     = wr_req && wr_ready;
   assign w_dma_rd_ok = dma_rd_req && is_full;
   assign w_pe_rd_ok  = pe_rd_req && is_draining;
   // DMA reads need FULL and PE reads need DRAINING, so they never collide.
   assign w_rd_addr   = w_pe_rd_ok ? pe_rd_addr : dma_addr;

   assign w_len_eff   = eff_fill_len(cfg_fill_len);
   assign w_count_inc = r_count + 7'd1;

   always_ff @(posedge clk_h) begin
      if (!rst_n) begin
         r_state    <= EMPTY;
         r_count    <= 7'd0;
         r_fill_len <= 7'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_fill_len <= w_fill_len_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_fill_len_nxt = r_fill_len;
      case (r_state)
         EMPTY: begin
            if (w_wr_ok) begin
               w_fill_len_nxt = w_len_eff;
               w_count_nxt    = 7'd1;
               w_state_nxt    = (w_len_eff == 7'd1) ? FULL : FILLING;
            end
         end
         FILLING: begin
            if (w_wr_ok) begin
               w_count_nxt = w_count_inc;
               if (w_count_inc == r_fill_len) begin
                  w_state_nxt = FULL;
               end
            end
         end
         FULL: begin
            if (pe_start) begin
               w_state_nxt = DRAINING;
            end
         end
         DRAINING: begin
            if (pe_done) begin
               w_state_nxt = EMPTY;
               w_count_nxt = 7'd0;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge clk_h) begin
      if (w_wr_ok) begin
         r_ram[dma_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk_h) begin
      if (!rst_n) begin
         rd_data      <= '0;
         dma_rd_valid <= 1'b0;
         pe_rd_valid  <= 1'b0;
      end else begin
         dma_rd_valid <= w_dma_rd_ok;
         pe_rd_valid  <= w_pe_rd_ok;
         if (w_dma_rd_ok || w_pe_rd_ok) begin
            rd_data <= r_ram[w_rd_addr];
         end
      end
   end

`ifdef PINGPONG_PARITY_EN
   logic r_par [BANK_DEPTH];
   logic r_par_err;

   // Even parity: stored bit makes the total count of ones even.
   always_ff @(posedge clk_h) begin
      if (w_wr_ok) begin
         r_par[dma_addr] <= ^wr_data;
      end
   end

   always_ff @(posedge clk_h) begin
      if (!rst_n) begin
         r_par_err <= 1'b0;
      end else begin
         r_par_err <= w_pe_rd_ok && ((^r_ram[w_rd_addr]) != r_par[w_rd_addr]);
      end
   end

   assign parity_err = r_par_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/pingpong_feature_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_feature_buffer
//  Purpose  : Dual-bank feature buffer between the SDRAM DMA and the PE
//             array. The DMA fills one bank while the PE array drains the
//             other; the DMA may also read back a FULL bank.
//             Optional parity: define PINGPONG_PARITY_EN.
//  Ports    : clk_h, rst_n                  clock / sync active-low reset
//             cfg_fill_len                  words per fill (0 or >64 => 64)
//             mem_selecter, mem_enable      DMA bank select / command
//             mem1_addr, mem2_addr          DMA addresses for bank0 / bank1
//             data_mem_in                   DMA write data
//             memory1_ready, memory2_ready  bank accepts DMA writes
//             mem_data_out, mem_rd_valid    DMA read data / valid
//             pe_bank_ready, pe_bank_sel    drain bank FULL / drain bank index
//             pe_start, pe_done             claim / release drain bank
//             pe_rd_en, pe_rd_addr          PE read strobe / address
//             pe_rd_data, pe_rd_valid       PE read data / valid
//             wr_drop_err                   sticky dropped-write flag
//             pe_parity_err                 PE read parity mismatch
//  Revision : 1.0 - initial release
// ============================================================================
module pingpong_feature_buffer #(
   parameter int DATA_W = pingpong_pkg::DATA_W,
   parameter int ADDR_W = pingpong_pkg::ADDR_W
) (
   input  logic              clk_h,
   input  logic              rst_n,
   input  logic [6:0]        cfg_fill_len,
   input  logic              mem_selecter,
   input  logic [1:0]        mem_enable,
   input  logic [ADDR_W-1:0] mem1_addr,
   input  logic [ADDR_W-1:0] mem2_addr,
   input  logic [DATA_W-1:0] data_mem_in,
   output logic              memory1_ready,
   output logic              memory2_ready,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_rd_valid,
   output logic              pe_bank_ready,
   output logic              pe_bank_sel,
   input  logic              pe_start,
   input  logic              pe_rd_en,
   input  logic [ADDR_W-1:0] pe_rd_addr,
   output logic [DATA_W-1:0] pe_rd_data,
   output logic              pe_rd_valid,
   input  logic              pe_done,
   output logic              wr_drop_err,
   output logic              pe_parity_err
);
   import pingpong_pkg::*;

   logic              w_wr;
   logic              w_rd;
   logic              r_pe_bank_sel;
   logic              r_wr_drop_err;
   logic [1:0]        w_ready;
   logic [1:0]        w_full;
   logic [1:0]        w_drain;
   logic [1:0]        w_dma_v;
   logic [1:0]        w_pe_v;
   logic [1:0]        w_perr;
   logic [DATA_W-1:0] w_rd_data0;
   logic [DATA_W-1:0] w_rd_data1;
   logic              w_release;
   logic              w_drop;

   // 2'b11 decodes to neither command, i.e. idle.
   assign w_wr = (mem_enable == MEM_WR);
   assign w_rd = (mem_enable == MEM_RD);

   pp_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
      .clk_h        (clk_h),
      .rst_n        (rst_n),
      .cfg_fill_len (cfg_fill_len),
      .wr_req       (w_wr && !mem_selecter),
      .dma_rd_req   (w_rd && !mem_selecter),
      .dma_addr     (mem1_addr),
      .wr_data      (data_mem_in),
      .pe_start     (pe_start && !r_pe_bank_sel),
      .pe_rd_req    (pe_rd_en && !r_pe_bank_sel),
      .pe_rd_addr   (pe_rd_addr),
      .pe_done      (pe_done && !r_pe_bank_sel),
      .wr_ready     (w_ready[0]),
      .is_full      (w_full[0]),
      .is_draining  (w_drain[0]),
      .rd_data      (w_rd_data0),
      .dma_rd_valid (w_dma_v[0]),
      .pe_rd_valid  (w_pe_v[0]),
      .parity_err   (w_perr[0])
   );

   pp_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
      .clk_h        (clk_h),
      .rst_n        (rst_n),
      .cfg_fill_len (cfg_fill_len),
      .wr_req       (w_wr && mem_selecter),
      .dma_rd_req   (w_rd && mem_selecter),
      .dma_addr     (mem2_addr),
      .wr_data      (data_mem_in),
      .pe_start     (pe_start && r_pe_bank_sel),
      .pe_rd_req    (pe_rd_en && r_pe_bank_sel),
      .pe_rd_addr   (pe_rd_addr),
      .pe_done      (pe_done && r_pe_bank_sel),
      .wr_ready     (w_ready[1]),
      .is_full      (w_full[1]),
      .is_draining  (w_drain[1]),
      .rd_data      (w_rd_data1),
      .dma_rd_valid (w_dma_v[1]),
      .pe_rd_valid  (w_pe_v[1]),
      .parity_err   (w_perr[1])
   );

   assign w_release = pe_done && w_drain[r_pe_bank_sel];
   assign w_drop    = w_wr && !w_ready[mem_selecter];

   always_ff @(posedge clk_h) begin
      if (!rst_n) begin
         r_pe_bank_sel <= 1'b0;
         r_wr_drop_err <= 1'b0;
      end else begin
         if (w_release) begin
            r_pe_bank_sel <= !r_pe_bank_sel;
         end
         if (w_drop) begin
            r_wr_drop_err <= 1'b1;
         end
      end
   end

   assign memory1_ready = w_ready[0];
   assign memory2_ready = w_ready[1];
   assign pe_bank_sel   = r_pe_bank_sel;
   assign pe_bank_ready = w_full[r_pe_bank_sel];
   assign wr_drop_err   = r_wr_drop_err;

   // At most one bank produces each kind of valid per cycle: the DMA targets
   // one bank, and only one bank can be DRAINING at a time.
   assign mem_rd_valid  = |w_dma_v;
   assign mem_data_out  = w_dma_v[1] ? w_rd_data1 : (w_dma_v[0] ? w_rd_data0 : '0);
   assign pe_rd_valid   = |w_pe_v;
   assign pe_rd_data    = w_pe_v[1] ? w_rd_data1 : (w_pe_v[0] ? w_rd_data0 : '0);
   assign pe_parity_err = |w_perr;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_feature_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pingpong_feature_buffer
//  Purpose  : Self-checking bench for pingpong_feature_buffer. Directed
//             stimulus pushes expected read results into queues; a monitor
//             pops and compares whenever a read valid appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pingpong_feature_buffer;
   import pingpong_pkg::*;

   logic         clk_h = 1'b0;
   logic         rst_n;
   logic [6:0]   cfg_fill_len;
   logic         mem_selecter;
   logic [1:0]   mem_enable;
   logic [5:0]   mem1_addr;
   logic [5:0]   mem2_addr;
   logic [255:0] data_mem_in;
   logic         memory1_ready;
   logic         memory2_ready;
   logic [255:0] mem_data_out;
   logic         mem_rd_valid;
   logic         pe_bank_ready;
   logic         pe_bank_sel;
   logic         pe_start;
   logic         pe_rd_en;
   logic [5:0]   pe_rd_addr;
   logic [255:0] pe_rd_data;
   logic         pe_rd_valid;
   logic         pe_done;
   logic         wr_drop_err;
   logic         pe_parity_err;

   typedef struct packed {
      logic [255:0] data;
      logic         perr;
   } exp_t;

   exp_t mem_q[$];
   exp_t pe_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk_h = ~clk_h;

   pingpong_feature_buffer dut (
      .clk_h         (clk_h),
      .rst_n         (rst_n),
      .cfg_fill_len  (cfg_fill_len),
      .mem_selecter  (mem_selecter),
      .mem_enable    (mem_enable),
      .mem1_addr     (mem1_addr),
      .mem2_addr     (mem2_addr),
      .data_mem_in   (data_mem_in),
      .memory1_ready (memory1_ready),
      .memory2_ready (memory2_ready),
      .mem_data_out  (mem_data_out),
      .mem_rd_valid  (mem_rd_valid),
      .pe_bank_ready (pe_bank_ready),
      .pe_bank_sel   (pe_bank_sel),
      .pe_start      (pe_start),
      .pe_rd_en      (pe_rd_en),
      .pe_rd_addr    (pe_rd_addr),
      .pe_rd_data    (pe_rd_data),
      .pe_rd_valid   (pe_rd_valid),
      .pe_done       (pe_done),
      .wr_drop_err   (wr_drop_err),
      .pe_parity_err (pe_parity_err)
   );

   function automatic logic [255:0] word(input int v);
      logic [63:0] x;
      x = 64'(v);
      return {x ^ 64'hDEAD_0000_0000_0000, x, ~x, x};
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      mem_enable  = MEM_IDLE;
      pe_start    = 1'b0;
      pe_rd_en    = 1'b0;
      pe_done     = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk_h);
      #1;
      drive_idle();
   endtask

   task automatic dma_wr(input logic bank, input int addr, input logic [255:0] d);
      mem_selecter = bank;
      mem_enable   = MEM_WR;
      if (bank) mem2_addr = 6'(addr);
      else      mem1_addr = 6'(addr);
      data_mem_in  = d;
   endtask

   task automatic dma_rd(input logic bank, input int addr);
      mem_selecter = bank;
      mem_enable   = MEM_RD;
      if (bank) mem2_addr = 6'(addr);
      else      mem1_addr = 6'(addr);
   endtask

   task automatic pe_rd(input int addr);
      pe_rd_en   = 1'b1;
      pe_rd_addr = 6'(addr);
   endtask

   // Scoreboard monitor: every read valid must match the oldest expectation.
   always @(negedge clk_h) begin
      if (rst_n === 1'b1) begin
         if (mem_rd_valid) begin
            if (mem_q.size() == 0) begin
               check("mem_rd_valid_unexpected", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = mem_q.pop_front();
               check("mem_data_out", mem_data_out, e.data);
            end
         end
         if (pe_rd_valid) begin
            if (pe_q.size() == 0) begin
               check("pe_rd_valid_unexpected", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = pe_q.pop_front();
               check("pe_rd_data", pe_rd_data, e.data);
               check("pe_parity_err", pe_parity_err, e.perr);
            end
         end else if (pe_parity_err) begin
            check("pe_parity_err_without_valid", 1'b1, 1'b0);
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      cfg_fill_len = 7'd4;
      mem_selecter = 1'b0;
      mem1_addr    = '0;
      mem2_addr    = '0;
      data_mem_in  = '0;
      pe_rd_addr   = '0;
      drive_idle();
      repeat (3) cycle();
      rst_n = 1'b1;

      // Reset state
      check("rst_memory1_ready", memory1_ready, 1'b1);
      check("rst_memory2_ready", memory2_ready, 1'b1);
      check("rst_pe_bank_ready", pe_bank_ready, 1'b0);
      check("rst_pe_bank_sel", pe_bank_sel, 1'b0);
      check("rst_mem_rd_valid", mem_rd_valid, 1'b0);
      check("rst_pe_rd_valid", pe_rd_valid, 1'b0);
      check("rst_wr_drop_err", wr_drop_err, 1'b0);
      check("rst_pe_parity_err", pe_parity_err, 1'b0);
      check("rst_mem_data_out", mem_data_out, 256'd0);
      check("rst_pe_rd_data", pe_rd_data, 256'd0);

      // Fill bank0 with 4 words
      for (int i = 0; i < 4; i++) begin
         dma_wr(1'b0, i, word(32'hA0 + i));
         cycle();
         if (i == 2) check("fill4_ready_before_last", memory1_ready, 1'b1);
      end
      check("fill4_memory1_ready", memory1_ready, 1'b0);
      check("fill4_memory2_ready", memory2_ready, 1'b1);
      check("fill4_pe_bank_ready", pe_bank_ready, 1'b1);
      check("fill4_pe_bank_sel", pe_bank_sel, 1'b0);

      // mem_enable=11 is idle: no drop error, no read valid
      mem_selecter = 1'b0;
      mem_enable   = 2'b11;
      cycle();
      check("enable11_no_drop", wr_drop_err, 1'b0);

      // DMA readback of FULL bank0; read of EMPTY bank1 yields nothing
      mem_q.push_back('{data: word(32'hA1), perr: 1'b0});
      dma_rd(1'b0, 1);
      cycle();
      dma_rd(1'b1, 0);
      cycle();

      // Write to FULL bank is dropped
      dma_wr(1'b0, 2, word(32'hFF));
      cycle();
      check("drop_wr_drop_err", wr_drop_err, 1'b1);
      check("drop_memory1_ready", memory1_ready, 1'b0);

      // Claim bank0 and read old data at addr 2
      pe_start = 1'b1;
      cycle();
      check("start_pe_bank_ready", pe_bank_ready, 1'b0);
      pe_q.push_back('{data: word(32'hA2), perr: 1'b0});
      pe_rd(2);
      cycle();

      // Concurrent: fill bank1 while draining bank0
      for (int k = 0; k < 4; k++) begin
         dma_wr(1'b1, k, word(32'hB0 + k));
         pe_q.push_back('{data: word(32'hA0 + 3 - k), perr: 1'b0});
         pe_rd(3 - k);
         cycle();
      end
      check("conc_memory2_ready", memory2_ready, 1'b0);
      check("conc_memory1_ready", memory1_ready, 1'b0);

      // Release bank0
      pe_done = 1'b1;
      cycle();
      check("done_memory1_ready", memory1_ready, 1'b1);
      check("done_pe_bank_sel", pe_bank_sel, 1'b1);
      check("done_pe_bank_ready", pe_bank_ready, 1'b1);

      // PE read of bank1 before claim is ignored
      pe_rd(0);
      cycle();
      pe_start = 1'b1;
      cycle();
      // PE read bank1 while a DMA read of the now-DRAINING bank1 is ignored
      pe_q.push_back('{data: word(32'hB3), perr: 1'b0});
      pe_rd(3);
      dma_rd(1'b1, 0);
      cycle();

      // Partial fill of bank0 then reset mid-operation
      dma_wr(1'b0, 0, word(1));
      cycle();
      dma_wr(1'b0, 1, word(2));
      cycle();
      check("partial_memory1_ready", memory1_ready, 1'b1);
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      check("rst2_memory1_ready", memory1_ready, 1'b1);
      check("rst2_memory2_ready", memory2_ready, 1'b1);
      check("rst2_pe_bank_ready", pe_bank_ready, 1'b0);
      check("rst2_pe_bank_sel", pe_bank_sel, 1'b0);
      check("rst2_wr_drop_err", wr_drop_err, 1'b0);

      // cfg_fill_len=0 means 64 words
      cfg_fill_len = 7'd0;
      for (int i = 0; i < 64; i++) begin
         dma_wr(1'b0, i, word(100 + i));
         cycle();
         if (i == 62) check("fill64_ready_before_last", memory1_ready, 1'b1);
      end
      check("fill64_memory1_ready", memory1_ready, 1'b0);
      check("fill64_pe_bank_ready", pe_bank_ready, 1'b1);

      // fill_len=1: single write goes straight to FULL
      cfg_fill_len = 7'd1;
      dma_wr(1'b1, 9, word(55));
      cycle();
      check("fill1_memory2_ready", memory2_ready, 1'b0);
      check("fill1_no_drop", wr_drop_err, 1'b0);

      mem_q.push_back('{data: word(163), perr: 1'b0});
      dma_rd(1'b0, 63);
      cycle();
      mem_q.push_back('{data: word(55), perr: 1'b0});
      dma_rd(1'b1, 9);
      cycle();

      pe_start = 1'b1;
      cycle();
`ifdef PINGPONG_PARITY_EN
      dut.u_bank0.r_ram[7][0] = ~dut.u_bank0.r_ram[7][0];
      pe_q.push_back('{data: word(107) ^ 256'd1, perr: 1'b1});
`else
      pe_q.push_back('{data: word(107), perr: 1'b0});
`endif
      pe_rd(7);
      cycle();
      pe_q.push_back('{data: word(108), perr: 1'b0});
      pe_rd(8);
      cycle();

      pe_done = 1'b1;
      cycle();
      check("done2_pe_bank_sel", pe_bank_sel, 1'b1);
      check("done2_pe_bank_ready", pe_bank_ready, 1'b1);
      check("done2_memory1_ready", memory1_ready, 1'b1);

      repeat (3) cycle();
      check("mem_q_drained", 256'(mem_q.size()), 256'd0);
      check("pe_q_drained", 256'(pe_q.size()), 256'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
